// File: rtl/sevenseg_mux_driver_if.sv
// ----------------------------------------------------------------------------
// sevenseg_mux_driver_if : digit data / display bus for the seven-seg scanner
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sevenseg_mux_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    frame_done;

  modport master (
    output digits_in, load, dp_in, blank_in,
    input  seg, dp, anode, frame_done
  );

  modport slave (
    input  digits_in, load, dp_in, blank_in,
    output seg, dp, anode, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/sevenseg_mux_driver.sv
// ----------------------------------------------------------------------------
// sevenseg_mux_driver : time-multiplexed hex seven-segment driver with dead time
// Optional leading-zero blanking: define SEVENSEG_LZ_BLANK_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sevenseg_mux_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  wire logic              clk,
  input  wire logic              reset,
  sevenseg_mux_driver_if.slave   bus
);

  localparam int CNT_W = 16;
  localparam int IDX_W = 3;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = {7{1'(SEG_ACTIVE_LOW != 0)}};
  localparam logic                  DP_OFF   = 1'(SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{1'(AN_ACTIVE_LOW != 0)}};

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;
      4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;
      default: glyph = 7'b1000111;
    endcase
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic                    wrap_q, wrap_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpo_q, dpo_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    frame_q, frame_d;

  logic [3:0]              nib;
  logic                    dp_sel;
  logic                    blank_sel;
  logic [NUM_DIGITS-1:0]   hot;
  logic                    lz;
  logic [6:0]              seg_lit;
  logic                    dp_lit;
`ifdef SEVENSEG_LZ_BLANK_EN
  logic [IDX_W-1:0]        msd;
`endif

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    hot       = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib       = digits_q[4*k +: 4];
        dp_sel    = dp_q[k];
        blank_sel = blank_q[k];
        hot[k]    = 1'b1;
      end
    end

    lz = 1'b0;
`ifdef SEVENSEG_LZ_BLANK_EN
    // Digit 0 is never suppressed, so the search starts at digit 1.
    msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (digits_q[4*k +: 4] != 4'h0) begin
        msd = IDX_W'(k);
      end
    end
    lz = (idx_q > msd);
`endif

    seg_lit = (blank_sel || lz) ? 7'h00 : glyph(nib);
    dp_lit  = dp_sel && !blank_sel;

    // The first cycle of every slot is dead time to avoid ghosting.
    if (cnt_q == '0) begin
      seg_d   = SEG_OFF;
      dpo_d   = DP_OFF;
      anode_d = AN_OFF;
    end else begin
      seg_d   = seg_lit ^ SEG_OFF;
      dpo_d   = dp_lit ^ DP_OFF;
      anode_d = hot ^ AN_OFF;
    end
    frame_d = wrap_q;

    digits_d = bus.load ? bus.digits_in : digits_q;
    dp_d     = bus.load ? bus.dp_in     : dp_q;
    blank_d  = bus.load ? bus.blank_in  : blank_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      digits_q <= '0;
      dp_q     <= '0;
      blank_q  <= '0;
      wrap_q   <= 1'b0;
      seg_q    <= SEG_OFF;
      dpo_q    <= DP_OFF;
      anode_q  <= AN_OFF;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      digits_q <= digits_d;
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      wrap_q   <= wrap_d;
      seg_q    <= seg_d;
      dpo_q    <= dpo_d;
      anode_q  <= anode_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dpo_q;
  assign bus.anode      = anode_q;
  assign bus.frame_done = frame_q;

endmodule

`default_nettype wire
